// File: rtl/alu_4_pkg.sv
// Shared ALU definitions: opcode encoding and default datapath width.
package alu_4_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_4_core.sv
// Combinational ALU datapath (ADD/SUB with carry-borrow, AND, XOR); zero latency.
// No handshake: result follows operands every cycle, no backpressure.
module alu_4_core
  import alu_4_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       f,
  input  logic             cci,
  output logic [WIDTH-1:0] nxt_d,
  output logic             nxt_co
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] c_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};
  assign c_ext = {{WIDTH{1'b0}}, cci};

  // The extra MSB of the subtraction is the borrow: it is set exactly when a < b + cci.
  assign sum  = a_ext + b_ext + c_ext;
  assign diff = a_ext - b_ext - c_ext;

  always_comb begin
    nxt_d  = '0;
    nxt_co = 1'b0;
    case (f)
      OP_ADD: {nxt_co, nxt_d} = sum;
      OP_SUB: {nxt_co, nxt_d} = diff;
      OP_AND: nxt_d = a & b;
      OP_XOR: nxt_d = a ^ b;
      default: begin
        nxt_d  = '0;
        nxt_co = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_4.sv
// Registered 4-bit ALU: one operation per cycle, result visible 1 cycle after sampling.
// No handshake or backpressure; synchronous active-high reset clears d/co.
module alu_4
  import alu_4_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  output logic [WIDTH-1:0] d,
  output logic             co,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       f,
  input  logic             cci,
  input  logic             clk,
  input  logic             rst
);

  logic [WIDTH-1:0] nxt_d;
  logic             nxt_co;
  logic [WIDTH-1:0] d_d;
  logic [WIDTH-1:0] d_q;
  logic             co_d;
  logic             co_q;

  alu_4_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (a),
    .b      (b),
    .f      (f),
    .cci    (cci),
    .nxt_d  (nxt_d),
    .nxt_co (nxt_co)
  );

  always_comb begin
    d_d  = nxt_d;
    co_d = nxt_co;
    if (rst) begin
      d_d  = '0;
      co_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    d_q  <= d_d;
    co_q <= co_d;
  end

  assign d  = d_q;
  assign co = co_q;

endmodule

// File: tb/tb_alu_4.sv
// Directed + random scoreboard bench for the registered 4-bit ALU.
module tb_alu_4;
  import alu_4_pkg::*;

  typedef struct {
    logic [3:0] d;
    logic       co;
    string      tag;
  } exp_t;

  logic [3:0] d;
  logic       co;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] f;
  logic       cci;
  logic       clk;
  logic       rst;

  exp_t       sb_q[$];
  int         checks;
  int         errors;
  logic [3:0] last_d;
  logic       last_co;

  alu_4 #(.WIDTH(4)) dut (
    .d   (d),
    .co  (co),
    .a   (a),
    .b   (b),
    .f   (f),
    .cci (cci),
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Independent reference: plain integer arithmetic, no shared code with the RTL.
  function automatic logic [4:0] model(input int ma, input int mb, input int mf,
                                       input int mc, input int mr);
    int r;
    int c;
    r = 0;
    c = 0;
    if (mr == 0) begin
      case (mf)
        0: begin r = (ma + mb + mc) % 16; c = ((ma + mb + mc) > 15) ? 1 : 0; end
        1: begin r = (ma - mb - mc + 32) % 16; c = (ma < mb + mc) ? 1 : 0; end
        2: r = ma & mb;
        default: r = ma ^ mb;
      endcase
    end
    model = {c[0], r[3:0]};
  endfunction

  task automatic drive(input logic [3:0] ta, input logic [3:0] tb_v, input logic [1:0] tf,
                       input logic tc, input logic tr);
    a   = ta;
    b   = tb_v;
    f   = tf;
    cci = tc;
    rst = tr;
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty d=%h co=%b required an expected entry", d, co);
    end else begin
      e = sb_q.pop_front();
      assert (d === e.d && co === e.co) else begin
        errors++;
        $error("FAIL %s d=%h co=%b required d=%h co=%b", e.tag, d, co, e.d, e.co);
      end
      last_d  = e.d;
      last_co = e.co;
    end
  endtask

  task automatic step(input logic [3:0] ta, input logic [3:0] tb_v, input logic [1:0] tf,
                      input logic tc, input logic tr, input logic [3:0] ed,
                      input logic eco, input string tag);
    exp_t e;
    drive(ta, tb_v, tf, tc, tr);
    e.d   = ed;
    e.co  = eco;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_hold(input string tag);
    checks++;
    assert (d === last_d && co === last_co) else begin
      errors++;
      $error("FAIL %s d=%h co=%b required d=%h co=%b", tag, d, co, last_d, last_co);
    end
  endtask

  initial begin
    exp_t       e;
    logic [4:0] m;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [1:0] rf;
    logic       rc;
    logic       rr;
    checks  = 0;
    errors  = 0;
    last_d  = '0;
    last_co = 1'b0;
    drive(4'h0, 4'h0, OP_ADD, 1'b0, 1'b1);
    @(negedge clk);

    // Reset held for two edges with ADD F+F presented
    step(4'hF, 4'hF, OP_ADD, 1'b0, 1'b1, 4'h0, 1'b0, "reset_edge1");
    step(4'hF, 4'hF, OP_ADD, 1'b0, 1'b1, 4'h0, 1'b0, "reset_edge2");
    step(4'hF, 4'hF, OP_ADD, 1'b0, 1'b0, 4'hE, 1'b1, "reset_release");

    // ADD with carry-in
    step(4'h7, 4'h8, OP_ADD, 1'b1, 1'b0, 4'h0, 1'b1, "add_7_8_c1");
    step(4'h3, 4'h4, OP_ADD, 1'b0, 1'b0, 4'h7, 1'b0, "add_3_4");

    // SUB with borrow
    step(4'h5, 4'h3, OP_SUB, 1'b0, 1'b0, 4'h2, 1'b0, "sub_5_3");
    step(4'h3, 4'h5, OP_SUB, 1'b1, 1'b0, 4'hD, 1'b1, "sub_3_5_b1");

    // Logic ops, cci ignored
    step(4'hC, 4'hA, OP_AND, 1'b0, 1'b0, 4'h8, 1'b0, "and_c_a");
    step(4'hC, 4'hA, OP_XOR, 1'b0, 1'b0, 4'h6, 1'b0, "xor_c_a");
    step(4'hC, 4'hA, OP_XOR, 1'b1, 1'b0, 4'h6, 1'b0, "xor_c_a_cci");
    step(4'hC, 4'hA, OP_AND, 1'b1, 1'b0, 4'h8, 1'b0, "and_c_a_cci");

    // Back-to-back, one op per edge
    step(4'h9, 4'h6, OP_ADD, 1'b0, 1'b0, 4'hF, 1'b0, "b2b_add");
    step(4'h9, 4'h6, OP_SUB, 1'b0, 1'b0, 4'h3, 1'b0, "b2b_sub");
    step(4'h9, 4'h6, OP_AND, 1'b0, 1'b0, 4'h0, 1'b0, "b2b_and");
    step(4'h9, 4'h6, OP_XOR, 1'b0, 1'b0, 4'hF, 1'b0, "b2b_xor");

    // Mid-stream reset drops the presented op, then resumes on current inputs
    step(4'h9, 4'h6, OP_ADD, 1'b0, 1'b0, 4'hF, 1'b0, "mid_add");
    step(4'h9, 4'h6, OP_SUB, 1'b0, 1'b1, 4'h0, 1'b0, "mid_rst");
    step(4'h9, 4'h6, OP_XOR, 1'b0, 1'b0, 4'hF, 1'b0, "mid_resume_xor");
    step(4'h9, 4'h6, OP_SUB, 1'b0, 1'b0, 4'h3, 1'b0, "mid_resume_sub");

    // Outputs hold between edges despite input changes and a mid-cycle reset
    step(4'h9, 4'h6, OP_ADD, 1'b1, 1'b0, 4'h0, 1'b1, "add_9_6_c1");
    drive(4'h1, 4'h2, OP_XOR, 1'b0, 1'b0);
    #2;
    check_hold("hold_inputs");
    drive(4'h1, 4'h2, OP_XOR, 1'b0, 1'b1);
    #1;
    check_hold("hold_async_rst");
    e.d   = 4'h0;
    e.co  = 1'b0;
    e.tag = "rst_at_edge";
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();

    // Wrap-around boundaries
    step(4'hF, 4'h1, OP_ADD, 1'b0, 1'b0, 4'h0, 1'b1, "add_wrap");
    step(4'hF, 4'hF, OP_ADD, 1'b1, 1'b0, 4'hF, 1'b1, "add_max");
    step(4'h0, 4'h1, OP_SUB, 1'b0, 1'b0, 4'hF, 1'b1, "sub_wrap");
    step(4'h0, 4'hF, OP_SUB, 1'b1, 1'b0, 4'h0, 1'b1, "sub_max_borrow");
    step(4'h5, 4'h4, OP_SUB, 1'b1, 1'b0, 4'h0, 1'b0, "sub_equal_no_borrow");

    // Random stream checked against the integer model
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rf = 2'($urandom_range(0, 3));
      rc = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 9) == 0);
      m  = model(int'(ra), int'(rb), int'(rf), int'(rc), int'(rr));
      step(ra, rb, rf, rc, rr, m[3:0], m[4], "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
